// File: rtl/three_way_rr_arbiter_pkg.sv
// Shared definitions for the three-way round-robin mux arbiter: select encodings,
// FSM states and index helpers used by the picker and the top level.
package three_way_rr_arbiter_pkg;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;

  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Modulo-3 increment; the unused code 11 folds back to input 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      SEL_IN0: nxt = SEL_IN1;
      SEL_IN1: nxt = SEL_IN2;
      default: nxt = SEL_IN0;
    endcase
    return nxt;
  endfunction

  function automatic logic [2:0] idx_to_oh(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      SEL_IN0: oh = 3'b001;
      SEL_IN1: oh = 3'b010;
      SEL_IN2: oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/three_way_rr_arbiter_rr_pick3.sv
// Combinational rotating priority picker: first requester in mask, searching
// start, start+1, start+2 (mod 3).
module rr_pick3
  import three_way_rr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] start,
  input  logic [2:0] mask,
  output logic       hit,
  output logic [2:0] win_oh,
  output logic [1:0] win_idx
);

  logic [3:0] cand;
  logic [1:0] order [3];

  // Padded to four bits so any 2-bit index is in range.
  assign cand = {1'b0, req & mask};

  always_comb begin
    order[0] = (start == 2'b11) ? SEL_IN0 : start;
    order[1] = next_idx(order[0]);
    order[2] = next_idx(order[1]);
  end

  always_comb begin
    hit     = 1'b0;
    win_idx = SEL_IN0;
    for (int k = 0; k < 3; k++) begin
      if (!hit && cand[order[k]]) begin
        hit     = 1'b1;
        win_idx = order[k];
      end
    end
    win_oh = hit ? idx_to_oh(win_idx) : 3'b000;
  end

endmodule

// File: rtl/three_way_rr_arbiter.sv
// Round-robin owner of a shared 3:1 mux with a hold timer that rotates a
// contended owner out after MAX_HOLD cycles; all outputs come straight from flops.
module three_way_rr_arbiter
  import three_way_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_reg;
  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic [2:0]       gnt_reg;
  logic [1:0]       sel_reg;
  logic             busy_reg;
  logic             preempt_reg;

  logic [1:0] pick_start;
  logic [2:0] pick_mask;
  logic       pick_hit;
  logic [2:0] pick_oh;
  logic [1:0] pick_idx;
  logic       own_req;

  // One picker serves both cases: from ptr when idle, from owner+1 over the
  // other requesters when granted.
  always_comb begin
    pick_start = ptr_reg;
    pick_mask  = 3'b111;
    if (state_reg == ST_GRANT) begin
      pick_start = next_idx(sel_reg);
      pick_mask  = ~gnt_reg;
    end
  end

  assign own_req = |(req & gnt_reg);

  rr_pick3 u_pick (
    .req     (req),
    .start   (pick_start),
    .mask    (pick_mask),
    .hit     (pick_hit),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= SEL_IN0;
      hold_cnt_reg <= '0;
      gnt_reg      <= 3'b000;
      sel_reg      <= SEL_IN0;
      busy_reg     <= 1'b0;
      preempt_reg  <= 1'b0;
    end else begin
      preempt_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_hit) begin
            state_reg    <= ST_GRANT;
            gnt_reg      <= pick_oh;
            sel_reg      <= pick_idx;
            busy_reg     <= 1'b1;
            ptr_reg      <= next_idx(pick_idx);
            hold_cnt_reg <= '0;
          end
        end
        ST_GRANT: begin
          if (!own_req) begin
            hold_cnt_reg <= '0;
            ptr_reg      <= next_idx(sel_reg);
            if (pick_hit) begin
              gnt_reg <= pick_oh;
              sel_reg <= pick_idx;
            end else begin
              state_reg <= ST_IDLE;
              gnt_reg   <= 3'b000;
              busy_reg  <= 1'b0;
            end
          end else if (!pick_hit) begin
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg < HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end else begin
            gnt_reg      <= pick_oh;
            sel_reg      <= pick_idx;
            ptr_reg      <= next_idx(sel_reg);
            hold_cnt_reg <= '0;
            preempt_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign busy    = busy_reg;
  assign preempt = preempt_reg;

endmodule

// File: tb/tb_three_way_rr_arbiter.sv
// Directed bench for three_way_rr_arbiter with default MAX_HOLD=8: reset,
// timed rotation, release handover, uncontended hold, wrap fairness, mid-grant reset.
module tb_three_way_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  int checks;
  int errors;

  logic [2:0] oh_tab  [3];
  logic [1:0] sel_tab [3];

  three_way_rr_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Output invariants sampled mid-cycle, every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (sel === 2'b11 || !$onehot0(gnt) || busy !== |gnt ||
          (gnt !== 3'b000 && gnt !== oh_tab[sel])) begin
        errors++;
        $display("FAIL invariant t=%0t gnt=%b sel=%b busy=%b", $time, gnt, sel, busy);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    req = 3'b111;
    step();
    step();
    checks++;
    if (gnt !== 3'b000 || sel !== 2'b00 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b sel=%b busy=%b preempt=%b want 000/00/0/0",
               gnt, sel, busy, preempt);
    end
    rst = 1'b0;
    step();
    checks++;
    if (gnt !== 3'b001 || sel !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b sel=%b busy=%b want 001/00/1", gnt, sel, busy);
    end
    $display("test_reset done: gnt=%b sel=%b", gnt, sel);
  endtask

  task automatic test_rotation();
    do_reset();
    req = 3'b111;
    step();
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (gnt !== oh_tab[g % 3] || sel !== sel_tab[g % 3] ||
            preempt !== ((k == 0) && (g > 0))) begin
          errors++;
          $display("FAIL rotation g=%0d k=%0d got gnt=%b sel=%b preempt=%b want %b/%b/%b",
                   g, k, gnt, sel, preempt, oh_tab[g % 3], sel_tab[g % 3], (k == 0) && (g > 0));
        end
        step();
      end
      $display("test_rotation: slot %0d owner gnt=%b", g, oh_tab[g % 3]);
    end
  endtask

  task automatic test_release_handover();
    do_reset();
    req = 3'b111;
    step();
    req = 3'b110;
    step();
    checks++;
    if (gnt !== 3'b010 || sel !== 2'b01 || preempt !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL handover got gnt=%b sel=%b preempt=%b busy=%b want 010/01/0/1",
               gnt, sel, preempt, busy);
    end
    req = 3'b000;
    step();
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0 || sel !== 2'b01) begin
      errors++;
      $display("FAIL release_idle got gnt=%b busy=%b sel=%b want 000/0/01", gnt, busy, sel);
    end
    $display("test_release_handover done: gnt=%b busy=%b", gnt, busy);
  endtask

  task automatic test_uncontended_hold();
    do_reset();
    req = 3'b100;
    for (int c = 0; c < 50; c++) begin
      step();
      checks++;
      if (gnt !== 3'b100 || sel !== 2'b10 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL hold c=%0d got gnt=%b sel=%b preempt=%b want 100/10/0", c, gnt, sel, preempt);
      end
    end
    // A counter stuck at zero means exactly 8 contended cycles before rotation.
    req = 3'b101;
    for (int c = 0; c < 7; c++) begin
      step();
      checks++;
      if (gnt !== 3'b100 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL hold_contend c=%0d got gnt=%b preempt=%b want 100/0", c, gnt, preempt);
      end
    end
    step();
    checks++;
    if (gnt !== 3'b001 || sel !== 2'b00 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL hold_preempt got gnt=%b sel=%b preempt=%b want 001/00/1", gnt, sel, preempt);
    end
    step();
    checks++;
    if (gnt !== 3'b001 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL preempt_pulse got gnt=%b preempt=%b want 001/0", gnt, preempt);
    end
    $display("test_uncontended_hold done: gnt=%b", gnt);
  endtask

  task automatic test_wrap();
    do_reset();
    req = 3'b010;
    step();
    req = 3'b000;
    step();
    req = 3'b101;
    step();
    checks++;
    if (gnt !== 3'b100 || sel !== 2'b10) begin
      errors++;
      $display("FAIL wrap_ptr2 got gnt=%b sel=%b want 100/10", gnt, sel);
    end
    req = 3'b001;
    step();
    checks++;
    if (gnt !== 3'b001 || sel !== 2'b00 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL wrap_2to0 got gnt=%b sel=%b preempt=%b want 001/00/0", gnt, sel, preempt);
    end
    $display("test_wrap done: gnt=%b", gnt);
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010;
    step();
    req = 3'b011;
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (gnt !== 3'b010) begin
      errors++;
      $display("FAIL mid_owner got gnt=%b want 010", gnt);
    end
    rst = 1'b1;
    step();
    checks++;
    if (gnt !== 3'b000 || sel !== 2'b00 || busy !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got gnt=%b sel=%b busy=%b preempt=%b want 000/00/0/0",
               gnt, sel, busy, preempt);
    end
    rst = 1'b0;
    req = 3'b110;
    step();
    checks++;
    if (gnt !== 3'b010 || sel !== 2'b01) begin
      errors++;
      $display("FAIL mid_regrant got gnt=%b sel=%b want 010/01", gnt, sel);
    end
    req = 3'b000;
    step();
    req = 3'b111;
    step();
    checks++;
    if (gnt !== 3'b100) begin
      errors++;
      $display("FAIL mid_ptr_after got gnt=%b want 100", gnt);
    end
    $display("test_reset_mid done: gnt=%b", gnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    oh_tab[0]  = 3'b001;
    oh_tab[1]  = 3'b010;
    oh_tab[2]  = 3'b100;
    sel_tab[0] = 2'b00;
    sel_tab[1] = 2'b01;
    sel_tab[2] = 2'b10;
    rst = 1'b1;
    req = 3'b000;
    test_reset();
    test_rotation();
    test_release_handover();
    test_uncontended_hold();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
